// File: rtl/fft_bitrev_input_loader.sv
// Ping-pong frame loader for the first FFT butterfly stage: sample k lands in
// slot bitrev(k) of the write bank; a completed bank is presented whole on packed buses.
module fft_bitrev_input_loader #(
  parameter int no_point    = 32,
  parameter int addr_width  = 5,
  parameter int in_frac_bit = 5,
  parameter int in_int_bit  = 4,
  parameter int data_width  = in_frac_bit + in_int_bit + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_width-1:0]            in_real,
  input  logic [data_width-1:0]            in_imag,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
  output logic [no_point*data_width-1:0]   out_real,
  output logic [no_point*data_width-1:0]   out_imag,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             frame_err,
  output logic [addr_width-1:0]            sample_idx
);

  localparam logic [addr_width-1:0] last_cnt = addr_width'(no_point - 1);

  logic [data_width-1:0] bank_re [0:1][0:no_point-1];
  logic [data_width-1:0] bank_im [0:1][0:no_point-1];
  logic [1:0]            full;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [addr_width-1:0] wr_cnt;

  logic                  accept;
  logic                  consume;
  logic                  cnt_done;
  logic [1:0]            full_nxt;

  function automatic logic [addr_width-1:0] bitrev(input logic [addr_width-1:0] a);
    logic [addr_width-1:0] r;
    r = '0;
    for (int i = 0; i < addr_width; i++) r[i] = a[addr_width-1-i];
    return r;
  endfunction

  // Both streams: a transfer happens on a rising edge where valid && ready;
  // the source must hold its data stable until that edge.
  assign in_ready   = !full[wr_bank];
  assign out_valid  = full[rd_bank];
  assign sample_idx = wr_cnt;

  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;
  assign cnt_done = (wr_cnt == last_cnt);

  // Fill and drain always target different banks, since a full bank is never written.
  always_comb begin
    full_nxt = full;
    if (accept && cnt_done) full_nxt[wr_bank] = 1'b1;
    if (consume)            full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < no_point; s++) begin
          bank_re[b][s] <= '0;
          bank_im[b][s] <= '0;
        end
      end
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_nxt;
      frame_err <= 1'b0;
      if (consume) rd_bank <= !rd_bank;
      if (accept) begin
        bank_re[wr_bank][bitrev(wr_cnt)] <= in_real;
        bank_im[wr_bank][bitrev(wr_cnt)] <= in_imag;
        if (cnt_done) begin
          wr_bank   <= !wr_bank;
          wr_cnt    <= '0;
          frame_err <= !in_last;
        end else if (in_last) begin
          // Short frame: drop it; stale slots get overwritten by the next frame.
          wr_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < no_point; j++) begin : g_out
    assign out_real[j*data_width +: data_width] = bank_re[rd_bank][j];
    assign out_imag[j*data_width +: data_width] = bank_im[rd_bank][j];
  end

endmodule
